// File: rtl/uart_rx_frame_if.sv
// Receive-side valid/ready handshake between uart_rx_frame and the host logic.
// The receiver uses the master modport; the consumer uses the slave modport.
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: start qualification, mid-bit sampling, MSB-first assembly,
// optional parity, stop check, and a valid/ready output holding one pending frame.
module uart_rx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            os_tick,
  input  logic            rx_in,
  uart_rx_frame_if.master rx_if,
  output logic            busy,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_d;
  logic                 sync1, rxs, rx_prev;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg, data_q;
  logic                 valid_q, par_bad;
  logic                 mid_half, mid_full, tick_clr, tick_inc;

  assign rx_if.rx_data  = data_q;
  assign rx_if.rx_valid = valid_q;
  assign busy           = (state != IDLE);
  assign mid_half       = os_tick && (tick_cnt == HALF_M1);
  assign mid_full       = os_tick && (tick_cnt == FULL_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    tick_clr = 1'b0;
    tick_inc = 1'b0;
    case (state)
      IDLE: begin
        if (os_tick && rx_prev && !rxs) begin
          state_d  = START;
          tick_clr = 1'b1;
        end
      end
      START: begin
        if (mid_half) begin
          tick_clr = 1'b1;
          state_d  = rxs ? IDLE : DATA;
        end else if (os_tick) begin
          tick_inc = 1'b1;
        end
      end
      DATA: begin
        if (mid_full) begin
          tick_clr = 1'b1;
          if (bit_cnt == LAST_BIT) state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end else if (os_tick) begin
          tick_inc = 1'b1;
        end
      end
      PARITY: begin
        if (mid_full) begin
          tick_clr = 1'b1;
          state_d  = STOP;
        end else if (os_tick) begin
          tick_inc = 1'b1;
        end
      end
      STOP: begin
        if (mid_full) begin
          tick_clr = 1'b1;
          state_d  = IDLE;
        end else if (os_tick) begin
          tick_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= 1'b1;
      rxs         <= 1'b1;
      rx_prev     <= 1'b1;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      par_bad     <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      sync1       <= rx_in;
      rxs         <= sync1;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;

      if (tick_clr)      tick_cnt <= '0;
      else if (tick_inc) tick_cnt <= tick_cnt + TW'(1);

      if (valid_q && rx_if.rx_ready) valid_q <= 1'b0;

      case (state)
        IDLE: if (os_tick) rx_prev <= rxs;
        START: begin
          if (mid_half && !rxs) begin
            bit_cnt <= '0;
            par_bad <= 1'b0;
          end
        end
        DATA: begin
          if (mid_full) begin
            shreg   <= {shreg[DATA_BITS-2:0], rxs};
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        PARITY: if (mid_full) par_bad <= (rxs != ((^shreg) ^ ODD));
        STOP: begin
          // Priority: framing error, then parity error, then load or overrun.
          // The later valid_q assignment overrides the handshake clear above.
          if (mid_full) begin
            rx_prev <= rxs;
            if (!rxs) begin
              frame_err <= 1'b1;
            end else if (par_bad) begin
              parity_err <= 1'b1;
            end else if (!valid_q || rx_if.rx_ready) begin
              data_q  <= shreg;
              valid_q <= 1'b1;
            end else begin
              overrun_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: an 8N1 instance and an 8E1 instance driven bit-serially,
// checked against a frame-level outcome model (vector table, corner sequences, random frames).
module tb_uart_rx_frame;
  localparam int OS  = 16;
  localparam int DB  = 8;
  localparam int DIV = 4;

  typedef struct {
    int         s;       // 0: no parity instance, 1: even parity instance
    logic [7:0] d;
    logic       p;
    logic       stp;
    logic       rdy_at;  // rx_ready pulsed on the stop-sample cycle
    int         gap;     // idle bit periods before the frame
    logic       cons;    // consume after the frame
    int         oc;      // 0 load/none, 1 frame_err, 2 parity_err, 3 overrun
    logic       ev;      // expected rx_valid afterwards
    logic [7:0] ed;      // expected rx_data when ev=1
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, os_tick = 1'b0;
  logic [1:0] line_v = 2'b11, rdy_v = 2'b00;
  logic [1:0] busy_v, fe_v, pe_v, oe_v, val_v;
  logic [DB-1:0] dat [2];
  int div = 0, ticks = 0;
  int checks = 0, errors = 0;
  int fe_cnt [2], pe_cnt [2], oe_cnt [2], ev_tick [2];
  int wide_cnt = 0;
  logic [1:0] pfe = '0, ppe = '0, poe = '0, pval = '0;
  logic exp_val [2];
  logic [7:0] exp_dat [2];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    div     <= (div == DIV - 1) ? 0 : div + 1;
    os_tick <= (div == DIV - 2);
    if (os_tick) ticks <= ticks + 1;
  end

  uart_rx_frame_if #(.DATA_BITS(DB)) if_n ();
  uart_rx_frame_if #(.DATA_BITS(DB)) if_p ();
  assign if_n.rx_ready = rdy_v[0];
  assign if_p.rx_ready = rdy_v[1];
  assign dat[0] = if_n.rx_data;
  assign dat[1] = if_p.rx_data;
  assign val_v  = {if_p.rx_valid, if_n.rx_valid};

  uart_rx_frame #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .os_tick(os_tick), .rx_in(line_v[0]), .rx_if(if_n.master),
    .busy(busy_v[0]), .frame_err(fe_v[0]), .parity_err(pe_v[0]), .overrun_err(oe_v[0]));

  uart_rx_frame #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .rst_n(rst_n), .os_tick(os_tick), .rx_in(line_v[1]), .rx_if(if_p.master),
    .busy(busy_v[1]), .frame_err(fe_v[1]), .parity_err(pe_v[1]), .overrun_err(oe_v[1]));

  // Pulse counters and event timestamps, sampled on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (fe_v[i]) fe_cnt[i] <= fe_cnt[i] + 1;
      if (pe_v[i]) pe_cnt[i] <= pe_cnt[i] + 1;
      if (oe_v[i]) oe_cnt[i] <= oe_cnt[i] + 1;
      if (fe_v[i] || pe_v[i] || oe_v[i] || (val_v[i] && !pval[i])) ev_tick[i] <= ticks;
    end
    if (|((fe_v & pfe) | (pe_v & ppe) | (oe_v & poe))) wide_cnt <= wide_cnt + 1;
    pfe  <= fe_v;
    ppe  <= pe_v;
    poe  <= oe_v;
    pval <= val_v;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
    end
  endtask

  task automatic wait_until(input int target);
    while (ticks < target) @(negedge clk);
  endtask

  task automatic drive_bit(input int s, input logic v, input int n);
    int t;
    line_v[s] = v;
    t = ticks;
    wait_until(t + n);
  endtask

  task automatic send_frame(input int s, input logic [7:0] d, input logic p, input logic stp,
                            input logic rdy_at, output int ss);
    int g;
    drive_bit(s, 1'b0, OS);
    for (int k = DB - 1; k >= 0; k--) drive_bit(s, d[k], OS);
    if (s == 1) drive_bit(s, p, OS);
    line_v[s] = stp;
    ss = ticks;
    if (rdy_at) begin
      wait_until(ss + OS / 2);
      g = 0;
      while (!os_tick && g < 2 * DIV) begin
        @(negedge clk);
        g++;
      end
      rdy_v[s] = 1'b1;
      @(negedge clk);
      rdy_v[s] = 1'b0;
    end
    wait_until(ss + OS);
  endtask

  task automatic consume(input int s, input string nm);
    int t;
    @(negedge clk);
    rdy_v[s] = 1'b1;
    @(negedge clk);
    rdy_v[s] = 1'b0;
    chk({nm, " valid cleared"}, 32'(val_v[s]), 32'd0);
    exp_val[s] = 1'b0;
    t = ticks;
    wait_until(t + 1);
  endtask

  // Frame-level outcome: stop error beats parity error beats load/overrun.
  function automatic vec_t predict(input vec_t v);
    vec_t r = v;
    r.ev = exp_val[v.s] && !v.rdy_at;
    r.ed = exp_dat[v.s];
    if (!v.stp) r.oc = 1;
    else if (v.s == 1 && (v.p != ^v.d)) r.oc = 2;
    else if (!exp_val[v.s] || v.rdy_at) begin
      r.oc = 0;
      r.ev = 1'b1;
      r.ed = v.d;
    end else r.oc = 3;
    return r;
  endfunction

  task automatic run_frame(input vec_t v, input string nm);
    int f0, p0, o0, ss, lat, gap;
    logic ev_exp;
    gap = v.gap;
    if (gap == 0 && line_v[v.s] == 1'b0) gap = 1;
    if (gap > 0) drive_bit(v.s, 1'b1, gap * OS);
    ev_exp = (v.oc != 0) || !exp_val[v.s];
    f0 = fe_cnt[v.s];
    p0 = pe_cnt[v.s];
    o0 = oe_cnt[v.s];
    send_frame(v.s, v.d, v.p, v.stp, v.rdy_at, ss);
    chk({nm, " frame_err"},   32'(fe_cnt[v.s] - f0), 32'(v.oc == 1));
    chk({nm, " parity_err"},  32'(pe_cnt[v.s] - p0), 32'(v.oc == 2));
    chk({nm, " overrun_err"}, 32'(oe_cnt[v.s] - o0), 32'(v.oc == 3));
    chk({nm, " rx_valid"}, 32'(val_v[v.s]), 32'(v.ev));
    if (v.ev) chk({nm, " rx_data"}, 32'(dat[v.s]), 32'(v.ed));
    chk({nm, " busy"}, 32'(busy_v[v.s]), 32'd0);
    if (ev_exp) begin
      lat = ev_tick[v.s] - ss;
      checks++;
      if (lat < OS / 2 || lat > OS / 2 + 2) begin
        errors++;
        $display("FAIL %s latency: got %0d ticks into stop bit, want %0d..%0d", nm, lat, OS / 2, OS / 2 + 2);
      end
    end
    exp_val[v.s] = v.ev;
    exp_dat[v.s] = v.ed;
    if (v.cons) consume(v.s, nm);
  endtask

  initial begin
    vec_t tbl [9];
    vec_t r;
    int e0, t;
    logic seen;

    //          s  d      p     stp   rdy   gap cons  oc ev    ed
    tbl[0] = '{0, 8'hA5, 1'b0, 1'b1, 1'b0, 2, 1'b1, 0, 1'b1, 8'hA5};
    tbl[1] = '{0, 8'h5A, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1, 1'b0, 8'h00};
    tbl[2] = '{1, 8'h3C, 1'b1, 1'b1, 1'b0, 2, 1'b0, 2, 1'b0, 8'h00};
    tbl[3] = '{1, 8'h3C, 1'b0, 1'b1, 1'b0, 1, 1'b1, 0, 1'b1, 8'h3C};
    tbl[4] = '{0, 8'h11, 1'b0, 1'b1, 1'b0, 2, 1'b0, 0, 1'b1, 8'h11};
    tbl[5] = '{0, 8'h22, 1'b0, 1'b1, 1'b0, 0, 1'b0, 3, 1'b1, 8'h11};
    tbl[6] = '{0, 8'h22, 1'b0, 1'b1, 1'b1, 0, 1'b1, 0, 1'b1, 8'h22};
    tbl[7] = '{1, 8'h96, 1'b0, 1'b1, 1'b0, 0, 1'b1, 0, 1'b1, 8'h96};
    tbl[8] = '{1, 8'h01, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1, 1'b0, 8'h00};
    for (int i = 0; i < 2; i++) begin
      exp_val[i] = 1'b0;
      exp_dat[i] = 8'h00;
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset%0d rx_valid", i), 32'(val_v[i]), 32'd0);
      chk($sformatf("reset%0d rx_data", i), 32'(dat[i]), 32'd0);
      chk($sformatf("reset%0d busy", i), 32'(busy_v[i]), 32'd0);
      chk($sformatf("reset%0d errs", i), 32'({fe_v[i], pe_v[i], oe_v[i]}), 32'd0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

    // False start: short low pulse must abort in START without any output.
    drive_bit(0, 1'b1, 2 * OS);
    e0 = fe_cnt[0] + pe_cnt[0] + oe_cnt[0];
    drive_bit(0, 1'b0, 4);
    chk("false start busy during low", 32'(busy_v[0]), 32'd1);
    drive_bit(0, 1'b1, 3 * OS);
    chk("false start busy after", 32'(busy_v[0]), 32'd0);
    chk("false start rx_valid", 32'(val_v[0]), 32'(exp_val[0]));
    chk("false start errs", 32'(fe_cnt[0] + pe_cnt[0] + oe_cnt[0] - e0), 32'd0);
    r = '{0, 8'h3C, 1'b0, 1'b1, 1'b0, 1, 1'b1, 0, 1'b1, 8'h3C};
    run_frame(r, "after false start");

    // Stop bit low, then the line stays low: no retrigger until it goes high.
    r = '{0, 8'h5A, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1, 1'b0, 8'h00};
    run_frame(r, "held low frame");
    seen = 1'b0;
    t = ticks;
    while (ticks < t + 3 * OS) begin
      @(negedge clk);
      if (busy_v[0]) seen = 1'b1;
    end
    chk("held low no retrigger", 32'(seen), 32'd0);
    chk("held low rx_valid", 32'(val_v[0]), 32'd0);
    r = '{0, 8'hC3, 1'b0, 1'b1, 1'b0, 1, 1'b1, 0, 1'b1, 8'hC3};
    run_frame(r, "after held low");

    consume(0, "rand pre0");
    consume(1, "rand pre1");
    for (int n = 0; n < 24; n++) begin
      r.s      = int'($urandom_range(0, 1));
      r.d      = 8'($urandom);
      r.p      = ($urandom_range(0, 99) < 80) ? ^r.d : ~(^r.d);
      r.stp    = ($urandom_range(0, 99) < 85);
      r.rdy_at = ($urandom_range(0, 99) < 25);
      r.gap    = int'($urandom_range(0, 2));
      r.cons   = ($urandom_range(0, 99) < 40);
      run_frame(predict(r), $sformatf("rand%0d", n));
    end

    // Reset asserted in the middle of the data bits with a frame pending.
    consume(0, "pre reset");
    r = '{0, 8'h81, 1'b0, 1'b1, 1'b0, 2, 1'b0, 0, 1'b1, 8'h81};
    run_frame(r, "pending before reset");
    drive_bit(0, 1'b1, OS);
    drive_bit(0, 1'b0, OS);
    drive_bit(0, 1'b1, OS);
    drive_bit(0, 1'b0, OS);
    drive_bit(0, 1'b1, 5);
    chk("mid frame busy before reset", 32'(busy_v[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid reset rx_valid", 32'(val_v[0]), 32'd0);
    chk("mid reset rx_data", 32'(dat[0]), 32'd0);
    chk("mid reset busy", 32'(busy_v[0]), 32'd0);
    chk("mid reset errs", 32'({fe_v[0], pe_v[0], oe_v[0]}), 32'd0);
    chk("mid reset other rx_valid", 32'(val_v[1]), 32'd0);
    for (int i = 0; i < 2; i++) begin
      exp_val[i] = 1'b0;
      exp_dat[i] = 8'h00;
    end
    line_v = 2'b11;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    r = '{0, 8'hFF, 1'b0, 1'b1, 1'b0, 2, 1'b1, 0, 1'b1, 8'hFF};
    run_frame(r, "after reset");

    chk("error pulse width", 32'(wide_cnt), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
